// File: rtl/histo_readout_pkg.sv
// Shared constants and types for the histogram core and its readout sequencer.
// Core and reader import these so latency and geometry stay in lockstep.
package histo_readout_pkg;

  localparam int HISTO_BINS       = 1024;
  localparam int HISTO_BIN_W      = 10;
  localparam int HISTO_DATA_W     = 24;
  localparam int HISTO_RD_LAT     = 3;
  localparam int HISTO_CLR_SETTLE = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    WAIT,
    PRESENT,
    DONE
  } rd_state_e;

endpackage

// File: rtl/histo_out_reg.sv
// Output holding register for the bin stream.
// Captures on load and holds everything stable until the sink accepts.
module histo_out_reg #(
  parameter int DATA_W = 24,
  parameter int BIN_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic [BIN_W-1:0]  in_bin,
  input  logic              in_first,
  input  logic              in_last,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [BIN_W-1:0]  bin,
  output logic              first,
  output logic              last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      bin   <= '0;
      first <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= in_data;
      bin   <= in_bin;
      first <= in_first;
      last  <= in_last;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/histo_readout.sv
// Readout sequencer: sweeps every histogram bin in read/clear mode,
// streams the counts out and latches the total pixel count.
module histo_readout
  import histo_readout_pkg::*;
#(
  parameter int BINS       = HISTO_BINS,
  parameter int BIN_W      = HISTO_BIN_W,
  parameter int DATA_W     = HISTO_DATA_W,
  parameter int SUM_W      = HISTO_DATA_W + HISTO_BIN_W,
  parameter int SETTLE_CYC = HISTO_CLR_SETTLE,
  parameter int RD_LAT     = HISTO_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              histo_rw,
  output logic [BIN_W-1:0]  histo_bin,
  input  logic [DATA_W-1:0] histo_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [BIN_W-1:0]  m_bin,
  output logic              m_first,
  output logic              m_last,
  output logic [SUM_W-1:0]  total
);

  localparam int CNT_MAX = (SETTLE_CYC > RD_LAT) ? SETTLE_CYC : RD_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(BINS - 1);

  rd_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [SUM_W-1:0] sum;
  logic             load;

  assign load = (state == WAIT) && (cnt == '0);

  histo_out_reg #(
    .DATA_W (DATA_W),
    .BIN_W  (BIN_W)
  ) u_out (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .in_data  (histo_data),
    .in_bin   (histo_bin),
    .in_first (histo_bin == '0),
    .in_last  (histo_bin == LAST_BIN),
    .ready    (m_ready),
    .valid    (m_valid),
    .data     (m_data),
    .bin      (m_bin),
    .first    (m_first),
    .last     (m_last)
  );

  // A start coinciding with the done pulse is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      histo_rw  <= 1'b1;
      histo_bin <= LAST_BIN;
      cnt       <= '0;
      sum       <= '0;
      total     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !done) begin
            state    <= SETTLE;
            histo_rw <= 1'b0;
            busy     <= 1'b1;
            sum      <= '0;
            cnt      <= CNT_W'(SETTLE_CYC - 1);
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            histo_bin <= '0;
            cnt       <= CNT_W'(RD_LAT - 1);
            state     <= WAIT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            sum   <= sum + SUM_W'(histo_data);
            state <= PRESENT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        PRESENT: begin
          if (m_valid && m_ready) begin
            if (m_last) begin
              state <= DONE;
            end else begin
              histo_bin <= histo_bin + BIN_W'(1);
              cnt       <= CNT_W'(RD_LAT - 1);
              state     <= WAIT;
            end
          end
        end
        DONE: begin
          histo_rw  <= 1'b1;
          histo_bin <= LAST_BIN;
          total     <= sum;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/histo_readout.md
Name: histo_readout

Overview:
- Readout sequencer for the 1024-bin pixel histogram accumulator.
- On a start pulse (frame end), it switches the accumulator into read/clear mode and sweeps every bin address.
- It captures each 24-bit count after the accumulator's fixed read latency and streams it out on a valid/ready interface with first/last markers.
- It accumulates the total pixel count and returns the accumulator to accumulate mode when the sweep is complete. It sits between the histogram core and the packetiser/host-transfer logic.

Parameters:
- BINS, 1024, number of bins swept (power of two).
- BIN_W, 10, bin address width, log2(BINS).
- DATA_W, 24, per-bin count width.
- SUM_W, 34, total-count width, DATA_W+BIN_W (cannot overflow).
- SETTLE_CYC, 4, cycles histo_rw is held low before the first bin address change.
- RD_LAT, 3, cycles from histo_bin change until histo_data is valid for that bin.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle request to read out and clear the histogram
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last bin handshake and rw restore
- histo_rw  out  1  1 = accumulate mode, 0 = read/clear mode
- histo_bin  out  BIN_W  bin address to accumulator
- histo_data  in  DATA_W  bin count from accumulator (updates only on bin address change)
- m_valid  out  1  stream data valid
- m_ready  in  1  stream sink ready
- m_data  out  DATA_W  bin count
- m_bin  out  BIN_W  bin index of m_data
- m_first  out  1  marks bin 0
- m_last  out  1  marks bin BINS-1
- total  out  SUM_W  sum of all bin counts of the last completed sweep

Behaviour:
Reset values:
- busy=0, done=0, histo_rw=1, histo_bin=BINS-1, m_valid=0, m_data=0, m_bin=0, m_first=0, m_last=0, total=0.
- Internal state is IDLE; the sum accumulator is cleared.

Idle conventions:
- histo_bin is parked at BINS-1 so that stepping to bin 0 is a real address change. The accumulator latches read data only on an address change.

State machine:
- IDLE: on start=1, go to SETTLE. Drive histo_rw=0, busy=1, clear the sum, load the settle counter with SETTLE_CYC-1. start while busy is ignored, with no queuing.
- SETTLE: count down. At zero, set histo_bin=0, load the latency counter with RD_LAT-1, go to WAIT.
- WAIT: count down. At zero, register histo_data into m_data and histo_bin into m_bin. Set m_first=(bin==0) and m_last=(bin==BINS-1). Assert m_valid and add histo_data to the sum. Go to PRESENT.
- PRESENT: hold m_data, m_bin, m_first, m_last and m_valid stable until m_valid&m_ready.
  - On handshake, if not last: drop m_valid, increment histo_bin, reload the latency counter, go to WAIT.
  - On handshake, if last: drop m_valid, go to DONE.
- DONE (one cycle):
  - Set histo_rw=1 and histo_bin=BINS-1.
  - Load total from the sum, including the final bin.
  - Pulse done=1, set busy=0, go to IDLE.

Timing and rules:
- Latency: first m_valid is asserted SETTLE_CYC+RD_LAT+1 cycles after the start cycle.
- With m_ready held at 1, the bin period is RD_LAT+1 cycles.
- histo_bin changes only on WAIT entry and never while m_valid is high.
- The accumulator clears each bin as it reads it, so each bin is presented exactly once per sweep.
- Backpressure: m_ready low for any duration stalls in PRESENT with all outputs stable. m_ready is not sampled when m_valid=0.
- start in the same cycle as done is ignored. A new sweep requires start while busy=0.
- total holds its value until the next DONE. It is unchanged during a sweep.
- Reset mid-sweep: all outputs return to reset values the next cycle, with histo_rw=1 and no done pulse. Bins not yet read keep their stale counts; the upstream owner is responsible for this.
- Sum arithmetic is unsigned, zero-extends DATA_W to SUM_W, and never wraps.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, SETTLE, WAIT, PRESENT, DONE);
  - the HISTO_BINS, HISTO_BIN_W and HISTO_DATA_W constants shared with the accumulator core;
  - the HISTO_RD_LAT and HISTO_CLR_SETTLE constants, so core and reader stay in lockstep.
- One natural sub-module: histo_out_reg, the output holding register with valid/ready hold semantics. Everything else stays flat.

Test Plan:
1. Preload the model histogram with bin0=5, bin1=0, bin1023=7 and all other bins 0; pulse start with m_ready=1 → 1024 beats in bin order. m_first only on bin 0 (data 5), m_last only on bin 1023 (data 7). done pulses once, total=12, histo_rw back to 1.
2. Start with m_ready=1 → first m_valid exactly SETTLE_CYC+RD_LAT+1=8 cycles after start. Consecutive beats are 4 cycles apart. histo_rw is low for the whole sweep.
3. Random m_ready, 30% duty, with all bins=0xFFFFFF → m_data/m_bin stay stable while stalled and histo_bin never changes while m_valid=1. total=1024*0xFFFFFF=0x3FFFFFC00, with no overflow.
4. Extra start pulses mid-sweep and in the done cycle → ignored: one sweep, one done, 1024 beats.
5. Assert rst at bin 300 with m_valid high → the next cycle m_valid=0, busy=0, histo_rw=1, histo_bin=1023, no done. A following start gives a full 0..1023 sweep.
6. Back-to-back sweeps with the second sweep's bins all zero → second total=0. Every second-sweep beat is 0, confirming clear-on-read.
